// File: rtl/rx_serial_8n1.sv
// 8N1 asynchronous serial receiver, LSB first, oversampled by a free-running bit timer.
// Each good byte is reported with a one-cycle strobe; a low stop bit is reported as a framing error.
module rx_serial_8n1 #(
  parameter int CLKS_PER_BIT = 434,
  parameter int CNT_W        = 13
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       entrada_serial,
  output logic [7:0] dados_ascii,
  output logic       pronto,
  output logic       erro,
  output logic [3:0] db_estado
);

  typedef enum logic [3:0] {
    S_IDLE      = 4'd0,
    S_START     = 4'd1,
    S_DATA      = 4'd2,
    S_STOP      = 4'd3,
    S_WAIT_IDLE = 4'd4
  } state_t;

  localparam logic [CNT_W-1:0] T_LAST = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] T_HALF = CNT_W'(CLKS_PER_BIT / 2 - 1);

  state_t           state_q, state_d;
  logic [1:0]       sync_q;
  logic [CNT_W-1:0] timer_q, timer_d;
  logic [7:0]       shift_q, shift_d;
  logic [2:0]       bit_idx_q, bit_idx_d;
  logic [7:0]       dados_q, dados_d;
  logic             pronto_q, pronto_d;
  logic             erro_q, erro_d;
  logic             rx_s;

  assign rx_s = sync_q[1];

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q   <= S_IDLE;
      sync_q    <= 2'b11;
      timer_q   <= '0;
      shift_q   <= '0;
      bit_idx_q <= '0;
      dados_q   <= '0;
      pronto_q  <= 1'b0;
      erro_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      sync_q    <= {sync_q[0], entrada_serial};
      timer_q   <= timer_d;
      shift_q   <= shift_d;
      bit_idx_q <= bit_idx_d;
      dados_q   <= dados_d;
      pronto_q  <= pronto_d;
      erro_q    <= erro_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    shift_d   = shift_q;
    bit_idx_d = bit_idx_q;
    dados_d   = dados_q;
    pronto_d  = 1'b0;
    erro_d    = 1'b0;
    timer_d   = (timer_q == T_LAST) ? '0 : timer_q + CNT_W'(1);

    unique case (state_q)
      S_IDLE: begin
        if (!rx_s) state_d = S_START;
      end
      S_START: begin
        // Mid start bit: a line that has already returned high was only a glitch.
        if (timer_q == T_HALF) begin
          if (!rx_s) begin
            state_d   = S_DATA;
            bit_idx_d = '0;
          end else begin
            state_d = S_IDLE;
          end
        end
      end
      S_DATA: begin
        if (timer_q == T_LAST) begin
          shift_d   = {rx_s, shift_q[7:1]};
          bit_idx_d = bit_idx_q + 3'd1;
          if (bit_idx_q == 3'd7) state_d = S_STOP;
        end
      end
      S_STOP: begin
        if (timer_q == T_LAST) begin
          if (rx_s) begin
            dados_d  = shift_q;
            pronto_d = 1'b1;
            state_d  = S_IDLE;
          end else begin
            erro_d  = 1'b1;
            state_d = S_WAIT_IDLE;
          end
        end
      end
      S_WAIT_IDLE: begin
        // A held-low line is a break, not a start bit; wait for it to release.
        if (rx_s) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    if (state_d != state_q) timer_d = '0;
  end

  // pronto/erro are single-cycle strobes with no ready: the consumer must take
  // dados_ascii in the cycle pronto is high (it stays valid until the next good frame).
  assign dados_ascii = dados_q;
  assign pronto      = pronto_q;
  assign erro        = erro_q;
  assign db_estado   = state_q;

endmodule
